// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan driver: shadowed BCD value, guard time, blank/blink masks.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl #(
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned GUARD_CYCLES = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] number,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned SLOT_W  = $clog2(SLOT_CYCLES);
    localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [15:0]        staged_q, staged_d;
    logic               pending_q, pending_d;
    logic [1:0]         digit_q, digit_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               blink_off_q, blink_off_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               frame_done_q, frame_done_d;

    logic [3:0]         blank_eff;
    logic [3:0]         nibble;
    logic               slot_wrap;
    logic               frame_wrap;
    logic [FRAME_W-1:0] frame_next;

    function automatic logic [6:0] encode(input logic [3:0] v);
        case (v)
            4'h0: encode = 7'b0111111;
            4'h1: encode = 7'b0000110;
            4'h2: encode = 7'b1011011;
            4'h3: encode = 7'b1001111;
            4'h4: encode = 7'b1100110;
            4'h5: encode = 7'b1101101;
            4'h6: encode = 7'b1111101;
            4'h7: encode = 7'b0000111;
            4'h8: encode = 7'b1111111;
            4'h9: encode = 7'b1101111;
            4'hA: encode = 7'b1110111;
            4'hB: encode = 7'b1111100;
            4'hC: encode = 7'b0111001;
            4'hD: encode = 7'b1011110;
            4'hE: encode = 7'b1111001;
            default: encode = 7'b1110001;
        endcase
    endfunction

`ifdef DISPLAY_SCAN_LZB_EN
    logic [3:0] lzb;
    always_comb begin
        lzb    = '0;
        lzb[3] = (shadow_q[15:12] == 4'h0);
        lzb[2] = lzb[3] && (shadow_q[11:8] == 4'h0);
        lzb[1] = lzb[2] && (shadow_q[7:4] == 4'h0);
        blank_eff = blank_mask | lzb;
    end
`else
    assign blank_eff = blank_mask;
`endif

    assign nibble     = shadow_q[{digit_q, 2'b00} +: 4];
    assign slot_wrap  = (slot_q == SLOT_W'(SLOT_CYCLES - 1));
    assign frame_wrap = slot_wrap && (digit_q == 2'd3);
    assign frame_next = frame_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        staged_d     = staged_q;
        pending_d    = pending_q;
        digit_d      = digit_q;
        slot_d       = slot_q;
        frame_d      = frame_q;
        blink_off_d  = blink_off_q;
        seg_d        = '0;
        an_d         = '1;
        frame_done_d = 1'b0;

        if (load) begin
            staged_d  = number;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) state_d = SCAN;
                if (load) begin
                    shadow_d  = number;
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    shadow_d  = staged_q;
                    pending_d = 1'b0;
                end
            end
            default: begin
                if (!enable) begin
                    state_d     = IDLE;
                    digit_d     = '0;
                    slot_d      = '0;
                    frame_d     = '0;
                    blink_off_d = 1'b0;
                end else begin
                    if (slot_q >= SLOT_W'(GUARD_CYCLES) && !blank_eff[digit_q]
                        && !(blink_off_q && blink_mask[digit_q])) begin
                        an_d  = ~(4'b0001 << digit_q);
                        seg_d = encode(nibble);
                    end
                    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
                    if (slot_wrap) digit_d = digit_q + 1'b1;
                    // A load arriving on the boundary cycle beats the staged value.
                    if (frame_wrap) begin
                        frame_done_d = 1'b1;
                        if (load) begin
                            shadow_d  = number;
                            pending_d = 1'b0;
                        end else if (pending_q) begin
                            shadow_d  = staged_q;
                            pending_d = 1'b0;
                        end
                        if (frame_next == FRAME_W'(BLINK_FRAMES)) begin
                            frame_d     = '0;
                            blink_off_d = ~blink_off_q;
                        end else begin
                            frame_d = frame_next;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            staged_q     <= '0;
            pending_q    <= 1'b0;
            digit_q      <= '0;
            slot_q       <= '0;
            frame_q      <= '0;
            blink_off_q  <= 1'b0;
            seg_q        <= '0;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            staged_q     <= staged_d;
            pending_q    <= pending_d;
            digit_q      <= digit_d;
            slot_q       <= slot_d;
            frame_q      <= frame_d;
            blink_off_q  <= blink_off_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SLOT_CYCLES=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
// k counts rising edges from the one that leaves IDLE; pins after edge k show scan count k-1.
module tb_display_scan_ctrl;

    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [3:0] DK = 4'b1111;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] number;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int k;
    int checks;
    int errors;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .SLOT_CYCLES (8),
        .GUARD_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .number    (number),
        .load      (load),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    task automatic cyc();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic run_to(input int t);
        while (k < t) cyc();
    endtask

    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ef);
        checks++;
        assert (an === ea) else begin
            errors++;
            $error("FAIL %s an: got %b want %b", tag, an, ea);
        end
        checks++;
        assert (seg === es) else begin
            errors++;
            $error("FAIL %s seg: got %b want %b", tag, seg, es);
        end
        checks++;
        assert (frame_done === ef) else begin
            errors++;
            $error("FAIL %s frame_done: got %b want %b", tag, frame_done, ef);
        end
    endtask

    initial begin
        checks = 0; errors = 0; k = -1;
        reset = 1'b1; enable = 1'b0; load = 1'b0; number = '0;
        blank_mask = '0; blink_mask = '0;
        #1 chk("reset", DK, 7'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_dark", DK, 7'b0, 1'b0);

        enable = 1'b1; number = 16'h5513; load = 1'b1;
        cyc();
        load = 1'b0;
        run_to(32);  chk("f0_d3_end",   4'b0111, S5, 1'b1);
        run_to(33);  chk("f1_guard0",   DK, 7'b0, 1'b0);
        run_to(35);  chk("f1_d0_first", 4'b1110, S3, 1'b0);
        run_to(40);  chk("f1_d0_last",  4'b1110, S3, 1'b0);
        run_to(41);  chk("f1_d1_guard", DK, 7'b0, 1'b0);
        run_to(43);  chk("f1_d1",       4'b1101, S1, 1'b0);
        run_to(51);  chk("f1_d2",       4'b1011, S5, 1'b0);
        run_to(59);  chk("f1_d3",       4'b0111, S5, 1'b0);
        run_to(64);  chk("f1_done",     4'b0111, S5, 1'b1);
        run_to(65);  chk("f2_done_low", DK, 7'b0, 1'b0);

        run_to(74);
        number = 16'h1234; load = 1'b1;
        cyc();
        load = 1'b0; number = 16'h9999;
        run_to(83);  chk("f2_d2_old",   4'b1011, S5, 1'b0);
        run_to(91);  chk("f2_d3_old",   4'b0111, S5, 1'b0);
        run_to(96);  chk("f2_done_old", 4'b0111, S5, 1'b1);
        run_to(99);  chk("f3_d0_new",   4'b1110, S4, 1'b0);
        run_to(107); chk("f3_d1_new",   4'b1101, S3, 1'b0);
        run_to(115); chk("f3_d2_new",   4'b1011, S2, 1'b0);
        run_to(123); chk("f3_d3_new",   4'b0111, S1, 1'b0);

        run_to(127);
        blink_mask = 4'b0011; blank_mask = 4'b1000;
        run_to(131); chk("f4_on_d0",    4'b1110, S4, 1'b0);
        run_to(139); chk("f4_on_d1",    4'b1101, S3, 1'b0);
        run_to(147); chk("f4_on_d2",    4'b1011, S2, 1'b0);
        run_to(155); chk("f4_blank_d3", DK, 7'b0, 1'b0);
        run_to(163); chk("f5_on_d0",    4'b1110, S4, 1'b0);
        run_to(195); chk("f6_off_d0",   DK, 7'b0, 1'b0);
        run_to(203); chk("f6_off_d1",   DK, 7'b0, 1'b0);
        run_to(211); chk("f6_off_d2",   4'b1011, S2, 1'b0);
        run_to(219); chk("f6_blank_d3", DK, 7'b0, 1'b0);
        run_to(227); chk("f7_off_d0",   DK, 7'b0, 1'b0);
        run_to(259); chk("f8_on_d0",    4'b1110, S4, 1'b0);

        run_to(268); chk("pre_drop",    4'b1101, S3, 1'b0);
        enable = 1'b0;
        cyc();       chk("drop_dark",   DK, 7'b0, 1'b0);
        run_to(271); chk("idle_hold",   DK, 7'b0, 1'b0);
        enable = 1'b1;
        cyc();
        run_to(273); chk("re_guard0",   DK, 7'b0, 1'b0);
        run_to(274); chk("re_guard1",   DK, 7'b0, 1'b0);
        run_to(275); chk("re_d0",       4'b1110, S4, 1'b0);
        run_to(290);
        blank_mask = 4'b0000;
        run_to(304); chk("re_done_d3",  4'b0111, S1, 1'b1);

        #2 reset = 1'b1;
        #1 chk("async_reset", DK, 7'b0, 1'b0);
        @(negedge clk);
        chk("reset_held", DK, 7'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
